// File: rtl/reorder_buffer_mc.sv
// In-order-retire reorder buffer: program-order allocation, CDB_N result buses, up to COMMIT_W retirements per cycle.
// Optional recovery flush input is compiled in when ROB_FLUSH_EN is defined.
module reorder_buffer_mc #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned CDB_N    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef ROB_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         alloc_valid,
    input  logic [4:0]                   alloc_rd,
    output logic                         alloc_ready,
    output logic [IDX_W-1:0]             alloc_tag,
    input  logic [CDB_N-1:0]             cdb_valid,
    input  logic [CDB_N*IDX_W-1:0]       cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]      cdb_data,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*5-1:0]        commit_rd,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic [IDX_W-1:0]             rob_head,
    output logic [IDX_W:0]               count,
    output logic                         empty,
    output logic                         full
);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic              busy_q [DEPTH];
    logic              done_q [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              flush_w;
    logic              alloc_fire;
    logic [CNT_W-1:0]  ncommit;
    logic              chain;
    logic [IDX_W-1:0]  cidx;
    logic              cdb_dup;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign alloc_ready = !flush_w && (count_q < CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q;
    assign rob_head    = head_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));

    // Retire slots form a contiguous run from the head; the first not-ready slot stops the chain.
    always_comb begin
        commit_valid = '0;
        commit_rd    = '0;
        commit_data  = '0;
        ncommit      = '0;
        chain        = !flush_w;
        cidx         = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            cidx  = head_q + IDX_W'(k);
            chain = chain && busy_q[cidx] && done_q[cidx] && (CNT_W'(k) < count_q);
            commit_valid[k]                 = chain;
            commit_rd[k*5 +: 5]             = rd_q[cidx];
            commit_data[k*DATA_W +: DATA_W] = data_q[cidx];
            if (chain) begin
                ncommit = ncommit + CNT_W'(1);
            end
        end
    end

    always_comb begin
        head_d  = head_q + ncommit[IDX_W-1:0];
        tail_d  = tail_q + IDX_W'(alloc_fire);
        count_d = count_q + CNT_W'(alloc_fire) - ncommit;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
                done_q[i] <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                rd_q[tail_q]   <= alloc_rd;
                data_q[tail_q] <= '0;
            end
            // Later buses overwrite earlier ones on a tag collision; busy is sampled pre-edge.
            for (int unsigned i = 0; i < CDB_N; i++) begin
                if (cdb_valid[i] && busy_q[cdb_tag[i*IDX_W +: IDX_W]]) begin
                    done_q[cdb_tag[i*IDX_W +: IDX_W]] <= 1'b1;
                    data_q[cdb_tag[i*IDX_W +: IDX_W]] <= cdb_data[i*DATA_W +: DATA_W];
                end
            end
            for (int unsigned k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k]) begin
                    busy_q[head_q + IDX_W'(k)] <= 1'b0;
                    done_q[head_q + IDX_W'(k)] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int unsigned i = 0; i < CDB_N; i++) begin
            for (int unsigned j = i + 1; j < CDB_N; j++) begin
                if (cdb_valid[i] && cdb_valid[j] &&
                    cdb_tag[i*IDX_W +: IDX_W] == cdb_tag[j*IDX_W +: IDX_W]) begin
                    cdb_dup = 1'b1;
                end
            end
        end
    end

    a_cdb_unique_tag: assert property (@(posedge clk) disable iff (rst) !cdb_dup);

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: queue-based program-order model checked every cycle, plus directed literal checks.
module tb_reorder_buffer_mc;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned CDB_N    = 2;

    logic                        clk;
    logic                        rst;
    logic                        alloc_valid;
    logic [4:0]                  alloc_rd;
    logic                        alloc_ready;
    logic [IDX_W-1:0]            alloc_tag;
    logic [CDB_N-1:0]            cdb_valid;
    logic [CDB_N*IDX_W-1:0]      cdb_tag;
    logic [CDB_N*DATA_W-1:0]     cdb_data;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W*5-1:0]       commit_rd;
    logic [COMMIT_W*DATA_W-1:0]  commit_data;
    logic [IDX_W-1:0]            rob_head;
    logic [IDX_W:0]              count;
    logic                        empty;
    logic                        full;
    logic                        flush_m;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef ROB_FLUSH_EN
    logic flush;
    assign flush_m = flush;
`else
    assign flush_m = 1'b0;
`endif

    reorder_buffer_mc #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .COMMIT_W(COMMIT_W), .CDB_N(CDB_N)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
        .rob_head(rob_head), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the ROB as a program-order queue of in-flight instructions.
    typedef struct {
        int unsigned tag;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    int unsigned mhead = 0;

    function automatic int unsigned exp_ncommit();
        int unsigned n = 0;
        if (flush_m) return 0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (k < mq.size() && mq[k].done) n++;
            else break;
        end
        return n;
    endfunction

    always @(posedge clk) begin : model
        int unsigned n, tail;
        logic fire;
        ent_t e;
        if (rst || flush_m) begin
            mq.delete();
            mhead = 0;
        end else begin
            fire = alloc_valid && (mq.size() < DEPTH);
            tail = (mhead + mq.size()) % DEPTH;
            n = exp_ncommit();
            repeat (n) void'(mq.pop_front());
            mhead = (mhead + n) % DEPTH;
            for (int unsigned i = 0; i < CDB_N; i++) begin
                if (cdb_valid[i]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].tag == int'(cdb_tag[i*IDX_W +: IDX_W])) begin
                            e = mq[j];
                            e.done = 1'b1;
                            e.data = cdb_data[i*DATA_W +: DATA_W];
                            mq[j] = e;
                        end
                    end
                end
            end
            if (fire) begin
                e.tag = tail; e.rd = alloc_rd; e.done = 1'b0; e.data = '0;
                mq.push_back(e);
            end
        end
    end

    logic started = 1'b0;

    always @(negedge clk) begin : compare
        int unsigned n;
        if (started && !rst) begin
            n = exp_ncommit();
            chk("alloc_ready", 64'(alloc_ready), 64'(!flush_m && (mq.size() < DEPTH)));
            chk("alloc_tag", 64'(alloc_tag), 64'((mhead + mq.size()) % DEPTH));
            chk("count", 64'(count), 64'(mq.size()));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
            chk("full", 64'(full), 64'(mq.size() == DEPTH));
            chk("rob_head", 64'(rob_head), 64'(mhead));
            chk("commit_valid", 64'(commit_valid), 64'((1 << n) - 1));
            for (int unsigned k = 0; k < n; k++) begin
                chk($sformatf("commit_rd[%0d]", k), 64'(commit_rd[k*5 +: 5]), 64'(mq[k].rd));
                chk($sformatf("commit_data[%0d]", k), 64'(commit_data[k*DATA_W +: DATA_W]), 64'(mq[k].data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_data    = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        started = 1'b1;
    endtask

    task automatic alloc(input logic [4:0] rd);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        tick();
    endtask

    task automatic cdb(input int unsigned bus, input logic [IDX_W-1:0] tag, input logic [31:0] data);
        cdb_valid[bus] = 1'b1;
        cdb_tag[bus*IDX_W +: IDX_W]   = tag;
        cdb_data[bus*DATA_W +: DATA_W] = data;
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_cv", 64'(commit_valid), 64'd0);
        chk("rst_head", 64'(rob_head), 64'd0);

        // Single alloc -> CDB -> commit
        alloc(5'd5);
        cdb(0, 4'd0, 32'hA5);
        tick();
        chk("t1_cv", 64'(commit_valid), 64'h1);
        chk("t1_rd", 64'(commit_rd[4:0]), 64'd5);
        chk("t1_data", 64'(commit_data[31:0]), 64'hA5);
        tick();
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_empty", 64'(empty), 64'd1);

        // Out-of-order completion, in-order dual retire
        do_reset();
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        cdb(0, 4'd1, 32'h11);
        tick();
        chk("t2_wait_cv", 64'(commit_valid), 64'h0);
        cdb(0, 4'd0, 32'h10);
        tick();
        chk("t2_cv", 64'(commit_valid), 64'h3);
        chk("t2_rd", 64'(commit_rd), 64'({5'd2, 5'd1}));
        chk("t2_data", 64'(commit_data), {32'h11, 32'h10});
        tick();
        chk("t2_head", 64'(rob_head), 64'd2);
        chk("t2_count", 64'(count), 64'd1);
        chk("t2_tag2_waits", 64'(commit_valid), 64'h0);
        cdb(1, 4'd2, 32'h22);
        tick();
        tick();

        // Fill, held-off alloc, commit frees slot only next cycle
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i));
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_ready", 64'(alloc_ready), 64'd0);
        chk("t3_count", 64'(count), 64'd16);
        alloc(5'd31);
        chk("t3_hold_count", 64'(count), 64'd16);
        chk("t3_hold_tag", 64'(alloc_tag), 64'd0);
        cdb(0, 4'd0, 32'h100);
        cdb(1, 4'd1, 32'h101);
        alloc_valid = 1'b1;
        tick();
        chk("t3_cv", 64'(commit_valid), 64'h3);
        chk("t3_ready_same", 64'(alloc_ready), 64'd0);
        alloc_valid = 1'b1;
        tick();
        chk("t3_ready_next", 64'(alloc_ready), 64'd1);
        chk("t3_count14", 64'(count), 64'd14);
        chk("t3_head2", 64'(rob_head), 64'd2);

        // Drain to head=15, then dual commit across the wrap
        for (int t = 2; t <= 14; t++) begin
            cdb(0, 4'(t), 32'(32'h100 + t));
            tick();
        end
        tick();
        chk("t4_head15", 64'(rob_head), 64'd15);
        chk("t4_count1", 64'(count), 64'd1);
        alloc(5'd7);
        cdb(0, 4'd15, 32'hF15);
        cdb(1, 4'd0, 32'h700);
        tick();
        chk("t4_cv", 64'(commit_valid), 64'h3);
        chk("t4_rd", 64'(commit_rd), 64'({5'd7, 5'd15}));
        chk("t4_data", 64'(commit_data), {32'h700, 32'hF15});
        tick();
        chk("t4_head1", 64'(rob_head), 64'd1);
        chk("t4_empty", 64'(empty), 64'd1);

        // Both buses complete head+0/head+1 in the same cycle (head=3)
        do_reset();
        for (int i = 10; i < 15; i++) alloc(5'(i));
        cdb(0, 4'd0, 32'h1); cdb(1, 4'd1, 32'h2);
        tick();
        cdb(0, 4'd2, 32'h3);
        tick();
        tick();
        chk("t5_head3", 64'(rob_head), 64'd3);
        cdb(0, 4'd3, 32'h33);
        cdb(1, 4'd4, 32'h44);
        tick();
        chk("t5_cv", 64'(commit_valid), 64'h3);
        chk("t5_rd", 64'(commit_rd), 64'({5'd14, 5'd13}));
        chk("t5_data", 64'(commit_data), {32'h44, 32'h33});
        tick();
        chk("t5_count", 64'(count), 64'd0);

        // rd=0 entry, CDB to a non-busy tag, and alloc with commit in the same cycle
        alloc(5'd0);
        cdb(0, 4'd9, 32'hDEAD);
        cdb(1, 4'd5, 32'hBEEF);
        alloc_valid = 1'b1; alloc_rd = 5'd6;
        tick();
        chk("t6_cv", 64'(commit_valid), 64'h1);
        chk("t6_data", 64'(commit_data[31:0]), 64'hBEEF);
        alloc_valid = 1'b1; alloc_rd = 5'd8;
        cdb(0, 4'd6, 32'h66);
        tick();
        chk("t6_count", 64'(count), 64'd2);
        tick();
        tick();

        // Reset mid-operation
        alloc(5'd3); alloc(5'd4);
        do_reset();
        chk("t7_count", 64'(count), 64'd0);
        chk("t7_tag", 64'(alloc_tag), 64'd0);

`ifdef ROB_FLUSH_EN
        for (int i = 1; i <= 6; i++) alloc(5'(i));
        cdb(0, 4'd0, 32'hA0); cdb(1, 4'd1, 32'hA1);
        tick();
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        #1;
        chk("t8_cv_flush", 64'(commit_valid), 64'h0);
        chk("t8_ready_flush", 64'(alloc_ready), 64'd0);
        tick();
        chk("t8_count", 64'(count), 64'd0);
        chk("t8_head", 64'(rob_head), 64'd0);
        chk("t8_tag", 64'(alloc_tag), 64'd0);
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
